// File: rtl/fpcmult_iter_shared.sv
// Fixed-point complex multiplier: c = a*b or a*conj(b).
// One shared radix-2 shift-add signed multiplier runs three Gauss products
// (P0=ar*br, P1=ac*bce, P2=(ar+ac)*(br+bce)) back to back. A fourth phase
// combines them at full precision, scales, and optionally saturates.
module fpcmult_iter_shared #(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter int sat = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  input  logic         conj,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         ovf
);

  localparam int W  = 2*n + 4;          // full product / combine width
  localparam int CW = $clog2(n + 2);    // multiplier bit counter width

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     phase_reg;            // 0..2 multiply phases, 3 = combine
  logic [CW-1:0]  bitcnt_reg;
  logic [n:0]     ar_reg, ac_reg, br_reg, bce_reg;
  logic [W-1:0]   mcand_reg;            // multiplicand, shifted left each step
  logic [n+1:0]   mplier_reg;           // multiplier, shifted right each step
  logic [W-1:0]   acc_reg;              // running product; holds P2 after phase 2
  logic [W-1:0]   p0_reg, p1_reg;
  logic [n-1:0]   cr_reg, cc_reg;
  logic           ovf_reg;

  logic           last_bit;
  logic [W-1:0]   addend, acc_step;
  logic [n+1:0]   sum_a, sum_b;
  logic [n:0]     bc_ext;
  logic [W-1:0]   full_w [2];
  logic [n-1:0]   res_w  [2];
  logic           oor_w  [2];

  assign last_bit = (bitcnt_reg == CW'(n + 1));
  assign addend   = mplier_reg[0] ? mcand_reg : '0;
  // The multiplier's top bit carries negative weight, so its step subtracts.
  assign acc_step = last_bit ? (acc_reg - addend) : (acc_reg + addend);
  // Pre-adds one bit wider than the registered operands: never overflow.
  assign sum_a    = {ar_reg[n], ar_reg} + {ac_reg[n], ac_reg};
  assign sum_b    = {br_reg[n], br_reg} + {bce_reg[n], bce_reg};
  assign bc_ext   = {bc[n-1], bc};

  // Real = P0 - P1, imaginary = P2 - P0 - P1, all at full precision.
  assign full_w[0] = p0_reg - p1_reg;
  assign full_w[1] = acc_reg - p0_reg - p1_reg;

  // Per component: floor-scale by d, range check, then wrap or clamp.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_scale
      logic signed [W-1:0] scaled;
      logic                in_range;
      assign scaled   = $signed(full_w[gi]) >>> d;
      assign in_range = (&scaled[W-1:n-1]) | ~(|scaled[W-1:n-1]);
      assign oor_w[gi] = ~in_range;
      assign res_w[gi] = ((sat != 0) && !in_range)
                         ? (scaled[W-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}})
                         : scaled[n-1:0];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake decode; handshake outputs depend on state only.
  always_comb begin
    state_next = state_reg;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    case (state_reg)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) state_next = MUL;
      end
      MUL: begin
        if (phase_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial multiply phases, combine into outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg  <= '0;
      bitcnt_reg <= '0;
      ar_reg     <= '0;
      ac_reg     <= '0;
      br_reg     <= '0;
      bce_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      p0_reg     <= '0;
      p1_reg     <= '0;
      cr_reg     <= '0;
      cc_reg     <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (recv_val) begin
            ar_reg     <= {ar[n-1], ar};
            ac_reg     <= {ac[n-1], ac};
            br_reg     <= {br[n-1], br};
            bce_reg    <= conj ? -bc_ext : bc_ext;
            mcand_reg  <= {{(W-n){ar[n-1]}}, ar};
            mplier_reg <= {{2{br[n-1]}}, br};
            acc_reg    <= '0;
            phase_reg  <= 2'd0;
            bitcnt_reg <= '0;
          end
        end
        MUL: begin
          if (phase_reg != 2'd3) begin
            mcand_reg  <= {mcand_reg[W-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[n+1:1]};
            bitcnt_reg <= bitcnt_reg + 1'b1;
            acc_reg    <= acc_step;
            if (last_bit) begin
              bitcnt_reg <= '0;
              phase_reg  <= phase_reg + 1'b1;
              case (phase_reg)
                2'd0: begin
                  p0_reg     <= acc_step;
                  acc_reg    <= '0;
                  mcand_reg  <= {{(W-n-1){ac_reg[n]}}, ac_reg};
                  mplier_reg <= {bce_reg[n], bce_reg};
                end
                2'd1: begin
                  p1_reg     <= acc_step;
                  acc_reg    <= '0;
                  mcand_reg  <= {{(W-n-2){sum_a[n+1]}}, sum_a};
                  mplier_reg <= sum_b;
                end
                default: ;  // phase 2: P2 stays in acc_reg
              endcase
            end
          end else begin
            cr_reg  <= res_w[0];
            cc_reg  <= res_w[1];
            ovf_reg <= oor_w[0] | oor_w[1];
          end
        end
        default: ;  // DONE: results held until the transfer
      endcase
    end
  end

  assign cr  = cr_reg;
  assign cc  = cc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_fpcmult_iter_shared.sv
// Self-checking bench: two instances (wrap and saturate) share stimulus.
// Table vectors, random operands against a direct complex-product model,
// plus backpressure and mid-operation reset sequences.
module tb_fpcmult_iter_shared;
  localparam int N   = 32;
  localparam int D   = 16;
  localparam int LAT = 3*(N+2) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic recv_val = 1'b0;
  logic send_rdy = 1'b1;
  logic conj = 1'b0;
  logic [N-1:0] ar = '0, ac = '0, br = '0, bc = '0;
  logic recv_rdy0, send_val0, ovf0, recv_rdy1, send_val1, ovf1;
  logic [N-1:0] cr0, cc0, cr1, cc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpcmult_iter_shared #(.n(N), .d(D), .sat(0)) dut0 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy0),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .conj(conj),
    .send_val(send_val0), .send_rdy(send_rdy), .cr(cr0), .cc(cc0), .ovf(ovf0));

  fpcmult_iter_shared #(.n(N), .d(D), .sat(1)) dut1 (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy1),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .conj(conj),
    .send_val(send_val1), .send_rdy(send_rdy), .cr(cr1), .cc(cc1), .ovf(ovf1));

  typedef struct {
    logic [31:0] ar, ac, br, bc;
    bit          cj;
    logic [31:0] cr, cc;     // wrap instance
    bit          ovf;
    logic [31:0] cr_s, cc_s; // saturating instance
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Clamp/wrap one component computed with plain wide arithmetic.
  function automatic void clamp(input logic signed [127:0] v, input bit s,
                                output logic [31:0] r, output bit o);
    logic signed [127:0] hi, lo;
    hi = 128'sh7FFFFFFF;
    lo = -128'sh80000000;
    o = (v > hi) || (v < lo);
    if (s && v > hi)      r = 32'h7FFFFFFF;
    else if (s && v < lo) r = 32'h80000000;
    else                  r = v[31:0];
  endfunction

  // Reference: textbook complex product, floor-scaled by 2^D.
  function automatic void model(input logic [31:0] a_r, a_c, b_r, b_c, input bit cj,
                                input bit s, output logic [31:0] r, output logic [31:0] im,
                                output bit o);
    logic signed [127:0] xr, xc, yr, yc, pr, pi;
    bit o_r, o_i;
    xr = $signed(a_r);
    xc = $signed(a_c);
    yr = $signed(b_r);
    yc = $signed(b_c);
    if (cj) yc = -yc;
    pr = (xr*yr - xc*yc) >>> D;
    pi = (xr*yc + xc*yr) >>> D;
    clamp(pr, s, r, o_r);
    clamp(pi, s, im, o_i);
    o = o_r | o_i;
  endfunction

  // Present operands and complete the accept handshake; scramble inputs after.
  task automatic start_op(input logic [31:0] a_r, a_c, b_r, b_c, input bit cj);
    int k;
    ar = a_r; ac = a_c; br = b_r; bc = b_c; conj = cj;
    recv_val = 1'b1;
    for (k = 0; k < 500 && !recv_rdy0; k++) begin
      @(posedge clk); #1;
    end
    if (!recv_rdy0) begin
      $display("FAIL accept_timeout: got recv_rdy=0 expected 1");
      $fatal(1, "accept timeout");
    end
    @(posedge clk); #1;
    recv_val = 1'b0;
    ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom; conj = 1'($urandom);
  endtask

  // Count edges after accept until send_val; bounded.
  task automatic wait_result(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      lat++;
      if (send_val0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_check(input logic [31:0] a_r, a_c, b_r, b_c, input bit cj,
                           input logic [31:0] e_cr, e_cc, input bit e_ovf,
                           input logic [31:0] e_crs, e_ccs, input bit e_ovfs,
                           input string tag);
    int lat;
    bit ok;
    send_rdy = 1'b1;
    start_op(a_r, a_c, b_r, b_c, cj);
    wait_result(lat, ok);
    check({tag, "_done"}, 64'(ok), 64'(1));
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_sendval_sat"}, 64'(send_val1), 64'(1));
    check({tag, "_cr"}, 64'(cr0), 64'(e_cr));
    check({tag, "_cc"}, 64'(cc0), 64'(e_cc));
    check({tag, "_ovf"}, 64'(ovf0), 64'(e_ovf));
    check({tag, "_cr_sat"}, 64'(cr1), 64'(e_crs));
    check({tag, "_cc_sat"}, 64'(cc1), 64'(e_ccs));
    check({tag, "_ovf_sat"}, 64'(ovf1), 64'(e_ovfs));
    $display("[TB] %s ar=%h ac=%h br=%h bc=%h conj=%0d -> cr=%h cc=%h ovf=%0d | sat cr=%h cc=%h ovf=%0d lat=%0d",
             tag, a_r, a_c, b_r, b_c, cj, cr0, cc0, ovf0, cr1, cc1, ovf1, lat);
    @(posedge clk); #1;
    check({tag, "_released"}, 64'(send_val0), 64'(0));
  endtask

  initial begin
    logic [31:0] r0, i0, r1, i1, v[4];
    bit o0, o1, ok, stale;
    int lat;
    logic [31:0] hold_cr, hold_cc;

    vecs[0] = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
                32'hFFFB0000, 32'h000A0000, 1'b0, 32'hFFFB0000, 32'h000A0000};
    vecs[1] = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
                32'h000B0000, 32'h00020000, 1'b0, 32'h000B0000, 32'h00020000};
    vecs[2] = '{32'hFFFF8000, 32'h00004000, 32'h00008000, 32'h00008000, 1'b0,
                32'hFFFFA000, 32'hFFFFE000, 1'b0, 32'hFFFFA000, 32'hFFFFE000};
    vecs[3] = '{32'h00000001, 32'h00000000, 32'h00008000, 32'h00000000, 1'b0,
                32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00008000, 32'h00000000, 1'b0,
                32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h00000000};
    vecs[5] = '{32'h7FFF0000, 32'h00000000, 32'h00020000, 32'h00000000, 1'b0,
                32'hFFFE0000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 32'h00000000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_recv_rdy", 64'(recv_rdy0), 64'(1));
    check("reset_send_val", 64'(send_val0), 64'(0));
    check("reset_cr", 64'(cr0), 64'(0));
    check("reset_cc", 64'(cc0), 64'(0));
    check("reset_ovf", 64'(ovf0), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors.
    for (int t = 0; t < 6; t++) begin
      run_check(vecs[t].ar, vecs[t].ac, vecs[t].br, vecs[t].bc, vecs[t].cj,
                vecs[t].cr, vecs[t].cc, vecs[t].ovf, vecs[t].cr_s, vecs[t].cc_s, vecs[t].ovf,
                $sformatf("vec%0d", t));
    end

    // Random operands, mixing full-range and small values.
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < 4; j++) begin
        v[j] = $urandom;
        if ($urandom_range(0, 1) == 0) v[j] = {{12{v[j][19]}}, v[j][19:0]};
      end
      if (t == 0) begin
        v[0] = 32'h80000000; v[1] = 32'h80000000; v[2] = 32'h80000000; v[3] = 32'h80000000;
      end
      ok = 1'($urandom);
      model(v[0], v[1], v[2], v[3], ok, 1'b0, r0, i0, o0);
      model(v[0], v[1], v[2], v[3], ok, 1'b1, r1, i1, o1);
      run_check(v[0], v[1], v[2], v[3], ok, r0, i0, o0, r1, i1, o1, $sformatf("rnd%0d", t));
    end

    // Backpressure: result held in DONE, stray recv_val ignored.
    send_rdy = 1'b0;
    start_op(vecs[0].ar, vecs[0].ac, vecs[0].br, vecs[0].bc, 1'b0);
    wait_result(lat, ok);
    check("bp_done", 64'(ok), 64'(1));
    check("bp_cr", 64'(cr0), 64'(vecs[0].cr));
    hold_cr = cr0;
    hold_cc = cc0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        recv_val = 1'b1; ar = 32'h00050000; br = 32'h00050000;
      end
      @(posedge clk); #1;
      recv_val = 1'b0;
      check("bp_send_val", 64'(send_val0), 64'(1));
      check("bp_cr_stable", 64'(cr0), 64'(hold_cr));
      check("bp_cc_stable", 64'(cc0), 64'(hold_cc));
      check("bp_recv_rdy", 64'(recv_rdy0), 64'(0));
    end
    $display("[TB] backpressure held cr=%h cc=%h for 10 cycles", hold_cr, hold_cc);
    send_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_release_send_val", 64'(send_val0), 64'(0));
    check("bp_release_recv_rdy", 64'(recv_rdy0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_phantom_accept", 64'(recv_rdy0), 64'(1));

    // Reset 20 cycles into MUL abandons the operation.
    start_op(vecs[5].ar, vecs[5].ac, vecs[5].br, vecs[5].bc, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_recv_rdy", 64'(recv_rdy0), 64'(1));
    check("rst_send_val", 64'(send_val0), 64'(0));
    check("rst_cr", 64'(cr0), 64'(0));
    check("rst_cc", 64'(cc0), 64'(0));
    check("rst_ovf", 64'(ovf0), 64'(0));
    check("rst_cr_sat", 64'(cr1), 64'(0));
    stale = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      if (send_val0 || send_val1 || !recv_rdy0) stale = 1'b1;
    end
    check("rst_no_stale", 64'(stale), 64'(0));
    $display("[TB] reset mid-MUL: idle for 150 cycles, stale=%0d", stale);
    run_check(vecs[2].ar, vecs[2].ac, vecs[2].br, vecs[2].bc, vecs[2].cj,
              vecs[2].cr, vecs[2].cc, vecs[2].ovf, vecs[2].cr_s, vecs[2].cc_s, vecs[2].ovf,
              "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
